// File: rtl/wb_burst_reader.sv
// Wishbone B3 burst read initiator: fetches a linear word region into an FWFT FIFO.
// Optional stall statistics counter enabled by defining WB_BURST_READER_STATS_EN.
module wb_burst_reader #(
   parameter int FIFO_AW   = 4,
   parameter int BURST_LEN = 4
) (
   input  logic        wb_clk,
   input  logic        wb_rst,
`ifdef WB_BURST_READER_STATS_EN
   output logic [31:0] stall_cnt_o,
`endif
   input  logic        start_i,
   input  logic [31:0] base_adr_i,
   input  logic [15:0] len_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   output logic [31:0] wbm_adr_o,
   output logic [1:0]  wbm_bte_o,
   output logic [2:0]  wbm_cti_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_dat_o,
   input  logic        wbm_ack_i,
   input  logic        wbm_err_i,
   input  logic        wbm_rty_i,
   input  logic [31:0] wbm_dat_i,
   output logic [31:0] dout_o,
   output logic        dout_valid_o,
   input  logic        dout_ready_i
);

   localparam logic [FIFO_AW:0] DEPTH      = (FIFO_AW+1)'(2**FIFO_AW);
   localparam logic [FIFO_AW:0] BURST_FREE = (FIFO_AW+1)'(BURST_LEN);
   localparam logic [1:0]       LAST_BEAT  = 2'(BURST_LEN-1);
   localparam logic [2:0]       CTI_CLASSIC = 3'b000;
   localparam logic [2:0]       CTI_INCR    = 3'b010;
   localparam logic [2:0]       CTI_END     = 3'b111;
   localparam logic [1:0]       BTE_LINEAR  = 2'b00;
   localparam logic [1:0]       BTE_WRAP4   = 2'b01;

   typedef enum logic [2:0] {S_IDLE, S_DECIDE, S_BURST, S_SINGLE, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [31:0]         cur_adr_q, cur_adr_d;
   logic [15:0]         remaining_q, remaining_d;
   logic [1:0]          beat_q, beat_d;
   logic                err_q, err_d;
   logic                cyc_q, cyc_d;
   logic [31:0]         adr_q, adr_d;
   logic [1:0]          bte_q, bte_d;
   logic [2:0]          cti_q, cti_d;

   logic [31:0]         mem [2**FIFO_AW];
   logic [FIFO_AW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [FIFO_AW:0]    count_q;
   logic [FIFO_AW:0]    free;
   logic                push, pop;

   logic                bus_act, ack_ok, bus_err, bus_rty, start_acc, burst_ok;
   logic [31:0]         adr_nxt;

   // Slave responses only count while a cycle is actually on the bus; err beats ack.
   assign bus_act   = cyc_q & wbm_stb_o;
   assign bus_err   = bus_act & wbm_err_i;
   assign ack_ok    = bus_act & wbm_ack_i & ~wbm_err_i;
   assign bus_rty   = bus_act & wbm_rty_i & ~wbm_err_i & ~wbm_ack_i;
   assign start_acc = start_i & ((state_q == S_IDLE) | (state_q == S_DONE));
   assign free      = DEPTH - count_q;
   assign adr_nxt   = cur_adr_q + 32'd4;
   assign burst_ok  = (remaining_q >= 16'(BURST_LEN)) && (cur_adr_q[3:0] == 4'h0)
                      && (free >= BURST_FREE);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      cur_adr_d   = cur_adr_q;
      remaining_d = remaining_q;
      beat_d      = beat_q;
      err_d       = err_q;
      cyc_d       = cyc_q;
      adr_d       = adr_q;
      bte_d       = bte_q;
      cti_d       = cti_q;
      push        = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (start_acc) begin
               cur_adr_d   = base_adr_i & ~32'h3;
               remaining_d = len_i;
               err_d       = 1'b0;
               state_d     = S_DECIDE;
            end
         end
         S_DECIDE: begin
            if (remaining_q == 16'd0) begin
               state_d = S_DONE;
            end else if (burst_ok) begin
               cyc_d   = 1'b1;
               adr_d   = cur_adr_q;
               bte_d   = BTE_WRAP4;
               cti_d   = CTI_INCR;
               beat_d  = 2'd0;
               state_d = S_BURST;
            end else if (free != '0) begin
               cyc_d   = 1'b1;
               adr_d   = cur_adr_q;
               bte_d   = BTE_LINEAR;
               cti_d   = CTI_CLASSIC;
               state_d = S_SINGLE;
            end
         end
         S_BURST, S_SINGLE: begin
            if (bus_err) begin
               cyc_d   = 1'b0;
               bte_d   = BTE_LINEAR;
               cti_d   = CTI_CLASSIC;
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else if (ack_ok) begin
               push        = 1'b1;
               cur_adr_d   = adr_nxt;
               remaining_d = remaining_q - 16'd1;
               beat_d      = beat_q + 2'd1;
               if ((state_q == S_SINGLE) || (beat_q == LAST_BEAT)) begin
                  cyc_d   = 1'b0;
                  bte_d   = BTE_LINEAR;
                  cti_d   = CTI_CLASSIC;
                  state_d = S_DECIDE;
               end else begin
                  adr_d = adr_nxt;
                  cti_d = (beat_q == LAST_BEAT - 2'd1) ? CTI_END : CTI_INCR;
               end
            end else if (bus_rty) begin
               // Back off one cycle; DECIDE re-evaluates burst eligibility from here.
               cyc_d   = 1'b0;
               bte_d   = BTE_LINEAR;
               cti_d   = CTI_CLASSIC;
               state_d = S_DECIDE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) begin
         state_q     <= S_IDLE;
         cur_adr_q   <= '0;
         remaining_q <= '0;
         beat_q      <= '0;
         err_q       <= 1'b0;
         cyc_q       <= 1'b0;
         adr_q       <= '0;
         bte_q       <= BTE_LINEAR;
         cti_q       <= CTI_CLASSIC;
      end else begin
         state_q     <= state_d;
         cur_adr_q   <= cur_adr_d;
         remaining_q <= remaining_d;
         beat_q      <= beat_d;
         err_q       <= err_d;
         cyc_q       <= cyc_d;
         adr_q       <= adr_d;
         bte_q       <= bte_d;
         cti_q       <= cti_d;
      end
   end

   assign pop = (count_q != '0) & dout_ready_i;

   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + (FIFO_AW+1)'(1);
            2'b01:   count_q <= count_q - (FIFO_AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // NOTE: the storage array has no reset; validity is tracked by count_q alone.
   always_ff @(posedge wb_clk) begin
      if (push) mem[wr_ptr_q] <= wbm_dat_i;
   end

`ifdef WB_BURST_READER_STATS_EN
   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst)
         stall_cnt_o <= '0;
      else if (start_acc)
         stall_cnt_o <= '0;
      else if (bus_act && !wbm_ack_i && (stall_cnt_o != 32'hffff_ffff))
         stall_cnt_o <= stall_cnt_o + 32'd1;
   end
`endif

   assign busy_o       = (state_q == S_DECIDE) || (state_q == S_BURST) || (state_q == S_SINGLE);
   assign done_o       = (state_q == S_DONE);
   assign err_o        = err_q;
   assign wbm_adr_o    = adr_q;
   assign wbm_bte_o    = bte_q;
   assign wbm_cti_o    = cti_q;
   assign wbm_cyc_o    = cyc_q;
   assign wbm_stb_o    = cyc_q;
   assign wbm_we_o     = 1'b0;
   assign wbm_sel_o    = 4'hf;
   assign wbm_dat_o    = 32'h0;
   assign dout_valid_o = (count_q != '0);
   assign dout_o       = dout_valid_o ? mem[rd_ptr_q] : 32'h0;

endmodule

// File: tb/tb_wb_burst_reader.sv
// Randomised bench for wb_burst_reader: a memory-backed Wishbone slave plus a
// transfer-level model (expected word stream, address order, burst legality).
module tb_wb_burst_reader;

   localparam int DEPTH = 16;

   logic        wb_clk = 1'b0;
   logic        wb_rst;
   logic        start_i;
   logic [31:0] base_adr_i;
   logic [15:0] len_i;
   logic        busy_o, done_o, err_o;
   logic [31:0] wbm_adr_o;
   logic [1:0]  wbm_bte_o;
   logic [2:0]  wbm_cti_o;
   logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_dat_o;
   logic        wbm_ack_i, wbm_err_i, wbm_rty_i;
   logic [31:0] wbm_dat_i;
   logic [31:0] dout_o;
   logic        dout_valid_o, dout_ready_i;
`ifdef WB_BURST_READER_STATS_EN
   logic [31:0] stall_cnt_o;
`endif

   wb_burst_reader #(.FIFO_AW(4), .BURST_LEN(4)) dut (
      .wb_clk       (wb_clk),
      .wb_rst       (wb_rst),
`ifdef WB_BURST_READER_STATS_EN
      .stall_cnt_o  (stall_cnt_o),
`endif
      .start_i      (start_i),
      .base_adr_i   (base_adr_i),
      .len_i        (len_i),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .err_o        (err_o),
      .wbm_adr_o    (wbm_adr_o),
      .wbm_bte_o    (wbm_bte_o),
      .wbm_cti_o    (wbm_cti_o),
      .wbm_cyc_o    (wbm_cyc_o),
      .wbm_stb_o    (wbm_stb_o),
      .wbm_we_o     (wbm_we_o),
      .wbm_sel_o    (wbm_sel_o),
      .wbm_dat_o    (wbm_dat_o),
      .wbm_ack_i    (wbm_ack_i),
      .wbm_err_i    (wbm_err_i),
      .wbm_rty_i    (wbm_rty_i),
      .wbm_dat_i    (wbm_dat_i),
      .dout_o       (dout_o),
      .dout_valid_o (dout_valid_o),
      .dout_ready_i (dout_ready_i)
   );

   always #5 wb_clk = ~wb_clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   typedef struct {
      logic [31:0] adr;
      logic [2:0]  cti;
      int          t;
   } trans_t;

   // Transfer-level model state
   logic [31:0] exp_q [$];
   trans_t      trans_q [$];
   logic [31:0] nxt_adr = '0;
   int rem = 0, acked = 0, occupancy = 0, pop_idx = 0, exp_len = 0;
   int done_cnt = 0, done_base = 0, cyc_n = 0, stall_model = 0;
   int ack_prob = 100, ready_prob = 100, err_beat = -1, burst_beat = 0;
   bit noise = 0, rty_arm = 0, in_burst = 0;
   bit act = 0, act_prev = 0, do_ack = 0, do_err = 0, do_rty = 0;

   // Slave, bus monitor and stream consumer, all acting away from the active edge.
   always @(negedge wb_clk) begin
      if (!wb_rst) begin
         cyc_n++;
         check("valid", dout_valid_o, occupancy != 0);
         if (done_o) done_cnt++;
         act    = wbm_cyc_o & wbm_stb_o;
         do_ack = 0;
         do_err = 0;
         do_rty = 0;
         if (act) begin
            if (!act_prev) begin
               in_burst   = (wbm_cti_o == 3'b010);
               burst_beat = 0;
               trans_q.push_back('{adr: wbm_adr_o, cti: wbm_cti_o, t: cyc_n});
               if (in_burst) begin
                  check("burst_align", wbm_adr_o[3:0], 4'h0);
                  check("burst_rem", rem >= 4, 1);
                  check("burst_free", occupancy <= DEPTH - 4, 1);
               end
            end
            check("rem_pos", rem > 0, 1);
            check("adr", wbm_adr_o, nxt_adr);
            check("cti", wbm_cti_o, in_burst ? ((burst_beat == 3) ? 3'b111 : 3'b010) : 3'b000);
            check("bte", wbm_bte_o, in_burst ? 2'b01 : 2'b00);
            check("beat", burst_beat <= 3, 1);
            if (err_beat >= 0 && in_burst && burst_beat == err_beat) begin
               do_err   = 1;
               do_ack   = 1'($urandom_range(0, 1));
               err_beat = -1;
            end else if (rty_arm) begin
               do_rty  = 1;
               rty_arm = 0;
            end else begin
               do_ack = ($urandom_range(1, 100) <= ack_prob);
            end
            if (do_ack && !do_err) begin
               nxt_adr = nxt_adr + 32'd4;
               rem--;
               acked++;
               occupancy++;
               burst_beat++;
               check("overflow", occupancy <= DEPTH, 1);
            end
            if (!do_ack) stall_model++;
         end else if (noise) begin
            do_ack = 1'($urandom_range(0, 1));
            do_err = ($urandom_range(0, 7) == 0);
            do_rty = 1'($urandom_range(0, 1));
         end
         wbm_ack_i = do_ack;
         wbm_err_i = do_err;
         wbm_rty_i = do_rty;
         wbm_dat_i = act ? mem_word(wbm_adr_o) : $urandom;
         act_prev  = act;

         dout_ready_i = ($urandom_range(1, 100) <= ready_prob);
         if (dout_valid_o && dout_ready_i) begin
            if (pop_idx < exp_q.size()) check("data", dout_o, exp_q[pop_idx]);
            pop_idx++;
            occupancy--;
         end
      end
   end

   task automatic start_xfer(input logic [31:0] base, input int len);
      exp_q.delete();
      for (int i = 0; i < len; i++) exp_q.push_back(mem_word((base & ~32'h3) + 32'(4 * i)));
      nxt_adr     = base & ~32'h3;
      rem         = len;
      acked       = 0;
      pop_idx     = 0;
      exp_len     = len;
      done_base   = done_cnt;
      stall_model = 0;
      trans_q.delete();
      start_i    = 1'b1;
      base_adr_i = base;
      len_i      = 16'(len);
      @(negedge wb_clk);
      start_i    = 1'b0;
   endtask

   task automatic finish_xfer(input bit exp_err);
      int t = 0;
      while (busy_o && t < 5000) begin
         @(negedge wb_clk);
         t++;
      end
      check("busy_timeout", busy_o, 0);
      @(negedge wb_clk);
      check("done_cnt", done_cnt - done_base, exp_err ? 0 : 1);
      check("done_pulse", done_o, 0);
      check("err_o", err_o, exp_err);
      if (exp_err) exp_len = acked;
      else check("acked", acked, rem + acked == exp_len ? exp_len : -1);
`ifdef WB_BURST_READER_STATS_EN
      check("stall_cnt", stall_cnt_o, stall_model);
`endif
   endtask

   task automatic drain();
      int t = 0;
      while (pop_idx < exp_len && t < 5000) begin
         @(negedge wb_clk);
         t++;
      end
      repeat (2) @(negedge wb_clk);
      check("pop_cnt", pop_idx, exp_len);
      check("empty", dout_valid_o, 0);
   endtask

   logic [31:0] rb;
   int          rl;

   initial begin
      wb_rst       = 1'b1;
      start_i      = 1'b0;
      base_adr_i   = '0;
      len_i        = '0;
      dout_ready_i = 1'b0;
      wbm_ack_i    = 1'b0;
      wbm_err_i    = 1'b0;
      wbm_rty_i    = 1'b0;
      wbm_dat_i    = '0;
      repeat (3) @(negedge wb_clk);
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_err", err_o, 0);
      check("rst_cyc", wbm_cyc_o, 0);
      check("rst_stb", wbm_stb_o, 0);
      check("rst_adr", wbm_adr_o, 0);
      check("rst_cti", wbm_cti_o, 0);
      check("rst_bte", wbm_bte_o, 0);
      check("rst_we", wbm_we_o, 0);
      check("rst_sel", wbm_sel_o, 4'hf);
      check("rst_dat", wbm_dat_o, 0);
      check("rst_valid", dout_valid_o, 0);
      check("rst_dout", dout_o, 0);
      wb_rst = 1'b0;
      repeat (2) @(negedge wb_clk);

      // Two aligned bursts
      start_xfer(32'h100, 8);
      finish_xfer(0);
      drain();
      check("t1_ntrans", trans_q.size(), 2);
      if (trans_q.size() == 2) begin
         check("t1_adr0", trans_q[0].adr, 32'h100);
         check("t1_cti0", trans_q[0].cti, 3'b010);
         check("t1_adr1", trans_q[1].adr, 32'h110);
         check("t1_cti1", trans_q[1].cti, 3'b010);
      end

      // Unaligned head: three singles then one burst
      start_xfer(32'h104, 7);
      finish_xfer(0);
      drain();
      check("t2_ntrans", trans_q.size(), 4);
      if (trans_q.size() == 4) begin
         check("t2_adr0", trans_q[0].adr, 32'h104);
         check("t2_cti0", trans_q[0].cti, 3'b000);
         check("t2_adr2", trans_q[2].adr, 32'h10C);
         check("t2_adr3", trans_q[3].adr, 32'h110);
         check("t2_cti3", trans_q[3].cti, 3'b010);
      end

      // Consumer stalled: fetch stops once the FIFO is full
      ready_prob = 0;
      start_xfer(32'h400, 32);
      repeat (150) @(negedge wb_clk);
      check("bp_acked", acked, 16);
      check("bp_cyc", wbm_cyc_o, 0);
      check("bp_busy", busy_o, 1);
      check("bp_valid", dout_valid_o, 1);
      ready_prob = 100;
      finish_xfer(0);
      drain();

      // Bus error on beat 2 of the first burst
      ready_prob = 0;
      err_beat   = 2;
      start_xfer(32'h200, 8);
      finish_xfer(1);
      check("err_acked", acked, 2);
      check("err_valid", dout_valid_o, 1);
      ready_prob = 100;
      drain();

      // Zero length: done two cycles after start, error flag cleared
      start_xfer(32'h500, 0);
      check("len0_busy1", busy_o, 1);
      check("len0_done1", done_o, 0);
      check("len0_errclr", err_o, 0);
      @(negedge wb_clk);
      check("len0_done2", done_o, 1);
      check("len0_busy2", busy_o, 0);
      @(negedge wb_clk);
      check("len0_done3", done_o, 0);
      check("len0_nocyc", trans_q.size(), 0);

      // Retry on the first beat: one idle cycle, then reissue at the same address
      rty_arm = 1;
      start_xfer(32'h300, 4);
      finish_xfer(0);
      drain();
      check("rty_ntrans", trans_q.size(), 2);
      if (trans_q.size() == 2) begin
         check("rty_adr0", trans_q[0].adr, 32'h300);
         check("rty_adr1", trans_q[1].adr, 32'h300);
         check("rty_gap", trans_q[1].t - trans_q[0].t, 2);
      end

      // Address wrap at 2^32
      start_xfer(32'hFFFF_FFF8, 6);
      finish_xfer(0);
      drain();
      check("wrap_ntrans", trans_q.size(), 3);

      // Randomised transfers with slave wait states, backpressure and idle-bus noise
      noise = 1;
      for (int k = 0; k < 25; k++) begin
         rb = $urandom;
         if (k % 5 == 0) rb = 32'hFFFF_FFC0 + 32'($urandom_range(0, 15) * 4);
         rl = $urandom_range(0, 40);
         ack_prob   = $urandom_range(30, 100);
         ready_prob = $urandom_range(10, 100);
         start_xfer(rb, rl);
         finish_xfer(0);
         drain();
      end
      noise = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
